multicycle_ctrl: RTL and testbench

Multi-cycle sequencer for the RV32I core. It steps each instruction through the states FETCH, DECODE, EXEC, MEM and WB, and shares one memory port between instruction fetch and data access using a req/ack handshake. It consumes the decoded strobes from control_unit and drives the PC, IR, memory and register-file enables. A watchdog traps the core if memory stops answering.

---
 rtl/ctrl_pkg.sv | 46 ++++
 rtl/multicycle_ctrl_mem_wait_timer.sv | 44 ++++
 rtl/multicycle_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared types and constants for the multi-cycle RV32I sequencer:
// the 3-bit state encoding, the base opcodes that decode as legal,
// and the address / next-PC select encodings.
package ctrl_pkg;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_TRAP   = 3'd7
   } state_e;

   localparam int OPCODE_W = 7;

   localparam logic [OPCODE_W-1:0] OP_R      = 7'b0110011;
   localparam logic [OPCODE_W-1:0] OP_I      = 7'b0010011;
   localparam logic [OPCODE_W-1:0] OP_LOAD   = 7'b0000011;
   localparam logic [OPCODE_W-1:0] OP_STORE  = 7'b0100011;
   localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'b1100011;
   localparam logic [OPCODE_W-1:0] OP_LUI    = 7'b0110111;
   localparam logic [OPCODE_W-1:0] OP_AUIPC  = 7'b0010111;
   localparam logic [OPCODE_W-1:0] OP_JAL    = 7'b1101111;
   localparam logic [OPCODE_W-1:0] OP_JALR   = 7'b1100111;

   // Memory address source
   localparam logic ADDR_PC  = 1'b0;
   localparam logic ADDR_ALU = 1'b1;

   // Next-PC source
   localparam logic PC_PLUS4  = 1'b0;
   localparam logic PC_TARGET = 1'b1;

   // True for the nine base opcodes the core executes; anything else traps.
   function automatic logic is_legal_op(input logic [OPCODE_W-1:0] op);
      logic legal;
      case (op)
         OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
         OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: legal = 1'b1;
         default:                          legal = 1'b0;
      endcase
      return legal;
   endfunction

endpackage

// File: rtl/multicycle_ctrl_mem_wait_timer.sv
// Memory watchdog: counts consecutive request cycles without an
// acknowledge and flags the cycle on which the limit is reached, so the
// sequencer can divert to TRAP instead of waiting forever.
// MEM_TIMEOUT = 0 turns the watchdog off (timeout_o never asserts).
module mem_wait_timer #(
   parameter int MEM_TIMEOUT = 15
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clear_i,
   input  logic inc_i,
   output logic timeout_o
);

   localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [CW-1:0] LAST = CW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Next count: clear wins, otherwise count stalled cycles and stop at the limit.
   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != LAST)) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   // Count register, cleared by the asynchronous reset.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // The last allowed stalled cycle: an ack on this cycle still wins
   // because inc_i is only high when ack is low.
   assign timeout_o = (MEM_TIMEOUT != 0) && inc_i && (cnt_q == LAST);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer for the RV32I core. Steps each instruction through
// FETCH, DECODE, EXEC, MEM and WB, sharing one req/ack memory port between
// instruction fetch and data access, and traps on illegal opcodes or when
// memory stops answering.
// Optional build macro CTRL_PERF_EN adds cycle and retired-instruction
// counters (o_cycle_cnt, o_instret_cnt) of width CNT_W.
module multicycle_ctrl
   import ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 15
`ifdef CTRL_PERF_EN
   ,
   parameter int CNT_W = 32
`endif
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic [OPCODE_W-1:0] i_opcode,
   input  logic                i_reg_write,
   input  logic                i_mem_read,
   input  logic                i_mem_write,
   input  logic                i_branch,
   input  logic                i_jump,
   input  logic                i_branch_taken,
   input  logic                i_mem_ack,
   output logic                o_mem_req,
   output logic                o_mem_we,
   output logic                o_addr_sel,
   output logic                o_ir_write,
   output logic                o_pc_write,
   output logic                o_pc_sel,
   output logic                o_rf_write,
   output logic                o_retire,
   output logic                o_trap,
`ifdef CTRL_PERF_EN
   output logic [CNT_W-1:0]    o_cycle_cnt,
   output logic [CNT_W-1:0]    o_instret_cnt,
`endif
   output logic [2:0]          o_state
);

   state_e state_q;
   state_e state_d;

   logic req_c;
   logic we_c;
   logic addr_sel_c;
   logic ir_write_c;
   logic pc_write_c;
   logic pc_sel_c;
   logic rf_write_c;
   logic retire_c;

   logic wd_clear;
   logic wd_inc;
   logic wd_timeout;

   // A stalled memory cycle is any FETCH/MEM cycle without ack. Derived from
   // the state register directly so it does not loop through the next-state logic.
   assign wd_inc = ((state_q == ST_FETCH) || (state_q == ST_MEM)) && !i_mem_ack;

   // The watchdog restarts whenever a new memory phase begins.
   assign wd_clear = (state_d != state_q) &&
                     ((state_d == ST_FETCH) || (state_d == ST_MEM));

   mem_wait_timer #(
      .MEM_TIMEOUT (MEM_TIMEOUT)
   ) u_mem_wait_timer (
      .clk_i     (i_clk),
      .rst_i     (i_rst),
      .clear_i   (wd_clear),
      .inc_i     (wd_inc),
      .timeout_o (wd_timeout)
   );

   // Next-state and strobe decode; every strobe defaults low.
   always_comb begin
      state_d    = state_q;
      req_c      = 1'b0;
      we_c       = 1'b0;
      addr_sel_c = ADDR_PC;
      ir_write_c = 1'b0;
      pc_write_c = 1'b0;
      pc_sel_c   = PC_PLUS4;
      rf_write_c = 1'b0;
      retire_c   = 1'b0;
      case (state_q)
         ST_FETCH: begin
            req_c      = 1'b1;
            addr_sel_c = ADDR_PC;
            if (i_mem_ack) begin
               ir_write_c = 1'b1;
               state_d    = ST_DECODE;
            end else if (wd_timeout) begin
               state_d = ST_TRAP;
            end
         end
         ST_DECODE: begin
            state_d = is_legal_op(i_opcode) ? ST_EXEC : ST_TRAP;
         end
         ST_EXEC: begin
            // Memory access outranks branch; branch outranks jump (jump resolves in WB).
            if (i_mem_read || i_mem_write) begin
               state_d = ST_MEM;
            end else if (i_branch) begin
               pc_write_c = 1'b1;
               pc_sel_c   = i_branch_taken ? PC_TARGET : PC_PLUS4;
               retire_c   = 1'b1;
               state_d    = ST_FETCH;
            end else begin
               state_d = ST_WB;
            end
         end
         ST_MEM: begin
            req_c      = 1'b1;
            addr_sel_c = ADDR_ALU;
            we_c       = i_mem_write;
            if (i_mem_ack) begin
               // A write strobe marks a store even if read is also high.
               if (i_mem_write) begin
                  pc_write_c = 1'b1;
                  pc_sel_c   = PC_PLUS4;
                  retire_c   = 1'b1;
                  state_d    = ST_FETCH;
               end else begin
                  state_d = ST_WB;
               end
            end else if (wd_timeout) begin
               state_d = ST_TRAP;
            end
         end
         ST_WB: begin
            rf_write_c = i_reg_write;
            pc_write_c = 1'b1;
            pc_sel_c   = i_jump ? PC_TARGET : PC_PLUS4;
            retire_c   = 1'b1;
            state_d    = ST_FETCH;
         end
         ST_TRAP: begin
            state_d = ST_TRAP;
         end
         default: begin
            state_d = ST_TRAP;
         end
      endcase
   end

   // State register; reset aborts any state, including an open memory request.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= ST_FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   // Strobes are forced low while reset is held so an aborted request
   // drops immediately rather than showing the FETCH request.
   assign o_mem_req  = req_c      & ~i_rst;
   assign o_mem_we   = we_c       & ~i_rst;
   assign o_addr_sel = addr_sel_c & ~i_rst;
   assign o_ir_write = ir_write_c & ~i_rst;
   assign o_pc_write = pc_write_c & ~i_rst;
   assign o_pc_sel   = pc_sel_c   & ~i_rst;
   assign o_rf_write = rf_write_c & ~i_rst;
   assign o_retire   = retire_c   & ~i_rst;
   assign o_trap     = (state_q == ST_TRAP);
   assign o_state    = state_q;

`ifdef CTRL_PERF_EN
   logic [CNT_W-1:0] cycle_cnt_q;
   logic [CNT_W-1:0] cycle_cnt_d;
   logic [CNT_W-1:0] instret_cnt_q;
   logic [CNT_W-1:0] instret_cnt_d;

   // Counters run outside TRAP and wrap naturally at 2^CNT_W.
   always_comb begin
      cycle_cnt_d   = cycle_cnt_q;
      instret_cnt_d = instret_cnt_q;
      if (state_q != ST_TRAP) begin
         cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
         if (retire_c) begin
            instret_cnt_d = instret_cnt_q + CNT_W'(1);
         end
      end
   end

   // Performance counter registers.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         cycle_cnt_q   <= '0;
         instret_cnt_q <= '0;
      end else begin
         cycle_cnt_q   <= cycle_cnt_d;
         instret_cnt_q <= instret_cnt_d;
      end
   end

   assign o_cycle_cnt   = cycle_cnt_q;
   assign o_instret_cnt = instret_cnt_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl. A schedule model builds, per
// instruction, the expected cycle-by-cycle output vector and the ack pattern
// to drive; each scenario task plays its schedule and compares every cycle.
module tb_multicycle_ctrl;

   localparam int TO = 4;

   // Vector layout: [11:9] state, [8] req, [7] we, [6] addr_sel, [5] ir_write,
   // [4] pc_write, [3] pc_sel, [2] rf_write, [1] retire, [0] trap
   localparam logic [11:0] V_FWAIT = {3'd0, 1'b1, 8'b0};
   localparam logic [11:0] V_FACK  = {3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'b0};
   localparam logic [11:0] V_DEC   = {3'd1, 9'b0};
   localparam logic [11:0] V_EXEC  = {3'd2, 9'b0};
   localparam logic [11:0] V_TRAP  = {3'd7, 8'b0, 1'b1};
   localparam logic [11:0] V_ZERO  = 12'b0;

   logic       clk = 1'b0;
   logic       i_rst;
   logic [6:0] i_opcode;
   logic       i_reg_write, i_mem_read, i_mem_write, i_branch, i_jump;
   logic       i_branch_taken, i_mem_ack;
   logic       o_mem_req, o_mem_we, o_addr_sel, o_ir_write, o_pc_write;
   logic       o_pc_sel, o_rf_write, o_retire, o_trap;
   logic [2:0] o_state;
   logic [11:0] obs;

   int n_vec = 0;
   int n_err = 0;

   logic [11:0] exp_q[$];
   bit          ack_q[$];

   always #5 clk = ~clk;

   multicycle_ctrl #(.MEM_TIMEOUT(TO)) dut (
      .i_clk(clk), .i_rst(i_rst), .i_opcode(i_opcode),
      .i_reg_write(i_reg_write), .i_mem_read(i_mem_read), .i_mem_write(i_mem_write),
      .i_branch(i_branch), .i_jump(i_jump), .i_branch_taken(i_branch_taken),
      .i_mem_ack(i_mem_ack), .o_mem_req(o_mem_req), .o_mem_we(o_mem_we),
      .o_addr_sel(o_addr_sel), .o_ir_write(o_ir_write), .o_pc_write(o_pc_write),
      .o_pc_sel(o_pc_sel), .o_rf_write(o_rf_write), .o_retire(o_retire),
      .o_trap(o_trap), .o_state(o_state)
   );

   assign obs = {o_state, o_mem_req, o_mem_we, o_addr_sel, o_ir_write,
                 o_pc_write, o_pc_sel, o_rf_write, o_retire, o_trap};

   function automatic bit legal(input logic [6:0] op);
      return op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                        7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111};
   endfunction

   task automatic set_ctrl(input logic [6:0] op, input bit rw, rd, wr, br, jmp, tk);
      i_opcode = op; i_reg_write = rw; i_mem_read = rd; i_mem_write = wr;
      i_branch = br; i_jump = jmp; i_branch_taken = tk;
   endtask

   task automatic push(input logic [11:0] v, input bit a);
      exp_q.push_back(v);
      ack_q.push_back(a);
   endtask

   task automatic push_trap();
      for (int k = 0; k < 3; k++) push(V_TRAP, 1'($urandom));
   endtask

   // Reference schedule for the instruction currently on the control inputs.
   // fd / md: unacknowledged cycles before the ack in FETCH / MEM.
   task automatic build_instr(input int fd, input int md);
      logic [11:0] wb_v;
      wb_v = {3'd4, 4'b0, 1'b1, i_jump, i_reg_write, 1'b1, 1'b0};
      for (int k = 0; k < fd && k < TO; k++) push(V_FWAIT, 1'b0);
      if (fd >= TO) begin push_trap(); return; end
      push(V_FACK, 1'b1);
      push(V_DEC, 1'($urandom));
      if (!legal(i_opcode)) begin push_trap(); return; end
      if (i_mem_read || i_mem_write) begin
         push(V_EXEC, 1'($urandom));
         for (int k = 0; k < md && k < TO; k++)
            push({3'd3, 1'b1, i_mem_write, 1'b1, 6'b0}, 1'b0);
         if (md >= TO) begin push_trap(); return; end
         if (i_mem_write) begin
            push({3'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0}, 1'b1);
         end else begin
            push({3'd3, 1'b1, 1'b0, 1'b1, 6'b0}, 1'b1);
            push(wb_v, 1'($urandom));
         end
      end else if (i_branch) begin
         push({3'd2, 4'b0, 1'b1, i_branch_taken, 1'b0, 1'b1, 1'b0}, 1'($urandom));
      end else begin
         push(V_EXEC, 1'($urandom));
         push(wb_v, 1'($urandom));
      end
   endtask

   task automatic do_reset();
      i_rst = 1'b1;
      i_mem_ack = 1'b0;
      repeat (2) @(posedge clk);
      #1 i_rst = 1'b0;
   endtask

   task automatic test_reset();
      i_rst = 1'b1;
      set_ctrl(7'b0100011, 1, 1, 1, 0, 0, 0);
      i_mem_ack = 1'b1;
      #1;
      n_vec++;
      if (obs !== V_ZERO) begin
         n_err++; $display("FAIL reset_hold: observed %b expected %b", obs, V_ZERO);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_vec++;
      if (obs !== V_ZERO) begin
         n_err++; $display("FAIL reset_ack: observed %b expected %b", obs, V_ZERO);
      end
      @(posedge clk);
      #1 i_rst = 1'b0;
      set_ctrl(7'b0110011, 1, 0, 0, 0, 0, 0);
      build_instr(1, 0);
      for (int i = 0; i < exp_q.size(); i++) begin
         i_mem_ack = ack_q[i];
         @(negedge clk);
         n_vec++;
         if (obs !== exp_q[i]) begin
            n_err++; $display("FAIL post_reset cyc%0d: observed %b expected %b", i, obs, exp_q[i]);
         end
         @(posedge clk); #1;
      end
      exp_q.delete(); ack_q.delete();
   endtask

   typedef struct {
      logic [6:0] op;
      bit rw, rd, wr, br, jmp, tk;
      int fd, md;
   } dir_t;

   task automatic test_directed();
      dir_t tbl[8];
      tbl[0] = '{7'b0110011, 1, 0, 0, 0, 0, 0, 0, 0}; // ADD
      tbl[1] = '{7'b0000011, 1, 1, 0, 0, 0, 0, 0, 2}; // LW, 3 MEM cycles
      tbl[2] = '{7'b0100011, 0, 0, 1, 0, 0, 0, 0, 1}; // SW
      tbl[3] = '{7'b1100011, 0, 0, 0, 1, 0, 1, 0, 0}; // BEQ taken
      tbl[4] = '{7'b1100011, 0, 0, 0, 1, 0, 0, 2, 0}; // BNE not taken
      tbl[5] = '{7'b1101111, 1, 0, 0, 0, 1, 0, 1, 0}; // JAL
      tbl[6] = '{7'b0100011, 1, 1, 1, 0, 0, 0, 0, 0}; // read+write -> store
      tbl[7] = '{7'b1100011, 1, 0, 0, 1, 1, 0, 0, 0}; // branch+jump -> branch
      do_reset();
      foreach (tbl[t]) begin
         set_ctrl(tbl[t].op, tbl[t].rw, tbl[t].rd, tbl[t].wr, tbl[t].br, tbl[t].jmp, tbl[t].tk);
         build_instr(tbl[t].fd, tbl[t].md);
         for (int i = 0; i < exp_q.size(); i++) begin
            i_mem_ack = ack_q[i];
            @(negedge clk);
            n_vec++;
            if (obs !== exp_q[i]) begin
               n_err++;
               $display("FAIL directed%0d cyc%0d: observed %b expected %b", t, i, obs, exp_q[i]);
            end
            @(posedge clk); #1;
         end
         exp_q.delete(); ack_q.delete();
      end
   endtask

   task automatic test_back_to_back();
      logic [6:0] ops[9];
      ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
              7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111};
      do_reset();
      for (int n = 0; n < 60; n++) begin
         int c;
         bit rw, rd, wr, br, jmp;
         c = $urandom_range(0, 8);
         rw = 1'($urandom); rd = 0; wr = 0; br = 0; jmp = 0;
         case (c)
            2: begin rd = 1; rw = 1; end
            3: begin wr = 1; rd = 1'($urandom); end
            4: begin br = 1; jmp = 1'($urandom); end
            7, 8: begin jmp = 1; rw = 1; end
            default: ;
         endcase
         set_ctrl(ops[c], rw, rd, wr, br, jmp, 1'($urandom));
         build_instr($urandom_range(0, TO - 1), $urandom_range(0, TO - 1));
         for (int i = 0; i < exp_q.size(); i++) begin
            i_mem_ack = ack_q[i];
            @(negedge clk);
            n_vec++;
            if (obs !== exp_q[i]) begin
               n_err++;
               $display("FAIL random%0d op=%b cyc%0d: observed %b expected %b", n, ops[c], i, obs, exp_q[i]);
            end
            @(posedge clk); #1;
         end
         exp_q.delete(); ack_q.delete();
      end
   endtask

   task automatic test_illegal();
      for (int n = 0; n < 4; n++) begin
         logic [6:0] op;
         op = 7'b1111111;
         if (n > 0) begin
            do op = 7'($urandom); while (legal(op));
         end
         do_reset();
         set_ctrl(op, 1, 0, 0, 0, 0, 0);
         build_instr($urandom_range(0, 2), 0);
         for (int i = 0; i < exp_q.size(); i++) begin
            i_mem_ack = ack_q[i];
            @(negedge clk);
            n_vec++;
            if (obs !== exp_q[i]) begin
               n_err++;
               $display("FAIL illegal op=%b cyc%0d: observed %b expected %b", op, i, obs, exp_q[i]);
            end
            @(posedge clk); #1;
         end
         exp_q.delete(); ack_q.delete();
      end
   endtask

   task automatic test_timeout();
      // fetch never acked; fetch acked on last allowed cycle; load never acked in MEM
      for (int s = 0; s < 3; s++) begin
         do_reset();
         if (s == 2) set_ctrl(7'b0000011, 1, 1, 0, 0, 0, 0);
         else        set_ctrl(7'b0110011, 1, 0, 0, 0, 0, 0);
         case (s)
            0: build_instr(TO, 0);
            1: build_instr(TO - 1, 0);
            default: build_instr(0, TO);
         endcase
         for (int i = 0; i < exp_q.size(); i++) begin
            i_mem_ack = ack_q[i];
            @(negedge clk);
            n_vec++;
            if (obs !== exp_q[i]) begin
               n_err++;
               $display("FAIL timeout%0d cyc%0d: observed %b expected %b", s, i, obs, exp_q[i]);
            end
            @(posedge clk); #1;
         end
         exp_q.delete(); ack_q.delete();
      end
   endtask

   task automatic test_reset_mid_mem();
      do_reset();
      set_ctrl(7'b0000011, 1, 1, 0, 0, 0, 0);
      build_instr(0, TO);
      // FETCH-ack, DECODE, EXEC, two stalled MEM cycles
      for (int i = 0; i < 5; i++) begin
         i_mem_ack = ack_q[i];
         @(negedge clk);
         n_vec++;
         if (obs !== exp_q[i]) begin
            n_err++; $display("FAIL mid_mem_pre cyc%0d: observed %b expected %b", i, obs, exp_q[i]);
         end
         @(posedge clk); #1;
      end
      exp_q.delete(); ack_q.delete();
      #2 i_rst = 1'b1;
      #1;
      n_vec++;
      if (obs !== V_ZERO) begin
         n_err++; $display("FAIL mid_mem_abort: observed %b expected %b", obs, V_ZERO);
      end
      @(posedge clk);
      #1 i_rst = 1'b0;
      @(negedge clk);
      n_vec++;
      if (obs !== V_FWAIT) begin
         n_err++; $display("FAIL mid_mem_release: observed %b expected %b", obs, V_FWAIT);
      end
      @(posedge clk); #1;
   endtask

   initial begin
      i_rst = 1'b1;
      i_mem_ack = 1'b0;
      set_ctrl(7'b0, 0, 0, 0, 0, 0, 0);
      test_reset();
      test_directed();
      test_back_to_back();
      test_illegal();
      test_timeout();
      test_reset_mid_mem();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
